cmp_set_pipe: RTL

- Parametrised, pipelined successor to the ALU's load-upper/set-on-less-than sub-unit.
- Executes compare-class operations: LUI, SLT, SLTU, SEQ, MIN, MAX, MINU, MAXU.
- Two-stage valid/ready pipeline with backpressure and synchronous flush.
- Sits between the EX-stage operand muxes and the ALU result mux, so compare logic leaves the single-cycle ALU critical path.

---
 rtl/cmp_pkg.sv | 28 ++
 rtl/cmp_core.sv | 19 +
 rtl/cmp_set_pipe.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the compare/set pipeline: op codes and the stage-1 flag payload.
// The op enum is also consumed by the ALU decoder, so its encoding must stay fixed.
package cmp_pkg;

    typedef enum logic [2:0] {
        OP_LUI  = 3'b000,
        OP_SLTU = 3'b001,
        OP_SLT  = 3'b010,
        OP_SEQ  = 3'b011,
        OP_MINU = 3'b100,
        OP_MAXU = 3'b101,
        OP_MIN  = 3'b110,
        OP_MAX  = 3'b111
    } cmp_op_e;

    // Width-independent part of the stage-1 payload; operands are added by the top.
    typedef struct packed {
        cmp_op_e op;
        logic    eq;
        logic    lt_u;
        logic    lt_s;
    } cmp_flags_t;

    function automatic logic op_is_signed(input cmp_op_e op);
        return (op == OP_SLT) || (op == OP_MIN) || (op == OP_MAX);
    endfunction

endpackage

// File: rtl/cmp_core.sv
// Combinational equality / unsigned-less-than / signed-less-than generator.
module cmp_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             lt_u,
    output logic             lt_s
);

    always_comb begin
        eq   = (a == b);
        lt_u = ({1'b0, a} < {1'b0, b});
        // Differing signs decide directly; matching signs reduce to the unsigned compare.
        lt_s = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : lt_u;
    end

endmodule

// File: rtl/cmp_set_pipe.sv
// Two-stage valid/ready compare-class unit (LUI, SLT(U), SEQ, MIN/MAX(U)) with flush.
// S1 captures operands plus compare flags; S2 holds the selected result.
module cmp_set_pipe
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IMM_W = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic             out_eq,
    output logic             out_lt
);

    if ((WIDTH < 8) || (WIDTH % 2 != 0) || (IMM_W < 1) || (IMM_W > WIDTH)) begin : g_bad_params
        $fatal(1, "cmp_set_pipe: illegal WIDTH=%0d / IMM_W=%0d", WIDTH, IMM_W);
    end

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        cmp_flags_t       f;
    } s1_payload_t;

    logic        s1_valid_reg;
    logic        s2_valid_reg;
    s1_payload_t s1_reg;
    s1_payload_t s1_next;
    logic        core_eq;
    logic        core_lt_u;
    logic        core_lt_s;
    logic        s1_adv;
    logic        s2_adv;
    logic        in_fire;

    logic [WIDTH-1:0] r_next;
    logic             lt_next;

    cmp_core #(.WIDTH(WIDTH)) u_core (
        .a    (in_a),
        .b    (in_b),
        .eq   (core_eq),
        .lt_u (core_lt_u),
        .lt_s (core_lt_s)
    );

    assign s2_adv    = !s2_valid_reg || out_ready;
    assign s1_adv    = !s1_valid_reg || s2_adv;
    assign in_ready  = rst_n && s1_adv && !flush;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid_reg;

    always_comb begin
        s1_next.a      = in_a;
        s1_next.b      = in_b;
        s1_next.f.op   = cmp_op_e'(in_op);
        s1_next.f.eq   = core_eq;
        s1_next.f.lt_u = core_lt_u;
        s1_next.f.lt_s = core_lt_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else if (flush) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            if (s1_adv) s1_valid_reg <= in_fire;
            if (s2_adv) s2_valid_reg <= s1_valid_reg;
        end
    end

    // Operand payload needs no reset: it is only observed behind s1_valid_reg.
    always_ff @(posedge clk) begin
        if (in_fire) s1_reg <= s1_next;
    end

    // On equality MIN/MAX pick a, so ties go to the "a" side of each select.
    always_comb begin
        r_next  = '0;
        lt_next = s1_reg.f.lt_u;
        if (op_is_signed(s1_reg.f.op)) lt_next = s1_reg.f.lt_s;
        unique case (s1_reg.f.op)
            OP_LUI: begin
                r_next  = s1_reg.b << (WIDTH - IMM_W);
                lt_next = 1'b0;
            end
            OP_SLTU: r_next = WIDTH'(s1_reg.f.lt_u);
            OP_SLT:  r_next = WIDTH'(s1_reg.f.lt_s);
            OP_SEQ:  r_next = WIDTH'(s1_reg.f.eq);
            OP_MINU: r_next = (s1_reg.f.lt_u || s1_reg.f.eq) ? s1_reg.a : s1_reg.b;
            OP_MAXU: r_next = s1_reg.f.lt_u ? s1_reg.b : s1_reg.a;
            OP_MIN:  r_next = (s1_reg.f.lt_s || s1_reg.f.eq) ? s1_reg.a : s1_reg.b;
            OP_MAX:  r_next = s1_reg.f.lt_s ? s1_reg.b : s1_reg.a;
            default: r_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r  <= '0;
            out_eq <= 1'b0;
            out_lt <= 1'b0;
        end else if (s2_adv && s1_valid_reg) begin
            out_r  <= r_next;
            out_eq <= s1_reg.f.eq;
            out_lt <= lt_next;
        end
    end

endmodule
